// File: rtl/tlb_probe_array_pkg.sv
// rtl/tlb_probe_array_pkg.sv - shared sizes, probe FSM encoding, entry layout and result packing for the TLB probe array
package tlb_probe_array_pkg;

  localparam int TLBNUM_DEF = 16;
  localparam int GRP_DEF    = 4;
  localparam int IDX_W      = 4;

  localparam int VPN2_W = 19;
  localparam int ASID_W = 8;
  localparam int PFN_W  = 20;
  localparam int C_W    = 3;

  localparam int EHI_VPN2_MSB = 31;
  localparam int EHI_VPN2_LSB = 13;
  localparam int EHI_ASID_MSB = 7;

  localparam int RES_W         = 6;
  localparam int RES_VALID_BIT = 5;
  localparam int RES_FOUND_BIT = 4;
  localparam int RES_INDEX_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } probe_state_e;

  typedef struct packed {
    logic [VPN2_W-1:0] vpn2;
    logic [ASID_W-1:0] asid;
    logic              g;
    logic [PFN_W-1:0]  pfn0;
    logic [C_W-1:0]    c0;
    logic              d0;
    logic              v0;
    logic [PFN_W-1:0]  pfn1;
    logic [C_W-1:0]    c1;
    logic              d1;
    logic              v1;
  } tlb_entry_t;

  function automatic logic [RES_W-1:0] pack_result(input logic valid, input logic found,
                                                   input logic [IDX_W-1:0] index);
    logic [RES_W-1:0] r;
    r = '0;
    r[RES_VALID_BIT] = valid;
    r[RES_FOUND_BIT] = found;
    r[RES_INDEX_LSB +: IDX_W] = index;
    return r;
  endfunction

endpackage

// File: rtl/tlb_entry_match.sv
// rtl/tlb_entry_match.sv - compares one TLB entry against the probe key
module tlb_entry_match
  import tlb_probe_array_pkg::*;
(
  input  logic [VPN2_W-1:0] entry_vpn2,
  input  logic [ASID_W-1:0] entry_asid,
  input  logic              entry_g,
  input  logic [VPN2_W-1:0] key_vpn2,
  input  logic [ASID_W-1:0] key_asid,
  output logic              hit
);

  // Global entries ignore the ASID entirely.
  assign hit = (entry_vpn2 == key_vpn2) && (entry_g || (entry_asid == key_asid));

endmodule

// File: rtl/tlb_probe_array.sv
// rtl/tlb_probe_array.sv - flop-based TLB with TLBWI/TLBR ports and a multi-cycle grouped TLBP probe
module tlb_probe_array
  import tlb_probe_array_pkg::*;
#(
  parameter int TLBNUM = TLBNUM_DEF,
  parameter int GRP    = GRP_DEF
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              we,
  input  logic [IDX_W-1:0]  w_index,
  input  logic [VPN2_W-1:0] w_vpn2,
  input  logic [ASID_W-1:0] w_asid,
  input  logic              w_g,
  input  logic [PFN_W-1:0]  w_pfn0,
  input  logic [C_W-1:0]    w_c0,
  input  logic              w_d0,
  input  logic              w_v0,
  input  logic [PFN_W-1:0]  w_pfn1,
  input  logic [C_W-1:0]    w_c1,
  input  logic              w_d1,
  input  logic              w_v1,

  input  logic [IDX_W-1:0]  r_index,
  output logic [VPN2_W-1:0] r_vpn2,
  output logic [ASID_W-1:0] r_asid,
  output logic              r_g,
  output logic [PFN_W-1:0]  r_pfn0,
  output logic [C_W-1:0]    r_c0,
  output logic              r_d0,
  output logic              r_v0,
  output logic [PFN_W-1:0]  r_pfn1,
  output logic [C_W-1:0]    r_c1,
  output logic              r_d1,
  output logic              r_v1,

  input  logic              TLBP,
  input  logic [31:0]       EntryHi,
  output logic [RES_W-1:0]  TLBP_result
);

  localparam int NGRP  = TLBNUM / GRP;
  localparam int GRP_W = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam int SUB_W = (GRP > 1) ? $clog2(GRP) : 1;
  localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(NGRP - 1);

  tlb_entry_t entries [TLBNUM];

  probe_state_e      state_q, state_d;
  logic [GRP_W-1:0]  grp_q, grp_d;
  logic              found_q, found_d;
  logic [IDX_W-1:0]  index_q, index_d;
  logic [VPN2_W-1:0] key_vpn2_q;
  logic [ASID_W-1:0] key_asid_q;
  logic              load_key;

  logic [GRP-1:0]    hits;
  logic [SUB_W-1:0]  first_hit;
  logic [IDX_W-1:0]  scan_index;

  logic              unused_entryhi;
  assign unused_entryhi = ^EntryHi[EHI_VPN2_LSB-1:EHI_ASID_MSB+1];

  // Only the bits that gate a match are reset; data fields keep whatever they held.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TLBNUM; i++) begin
        entries[i].g  <= 1'b0;
        entries[i].v0 <= 1'b0;
        entries[i].v1 <= 1'b0;
      end
    end else if (we) begin
      entries[w_index] <= '{vpn2: w_vpn2, asid: w_asid, g: w_g,
                            pfn0: w_pfn0, c0: w_c0, d0: w_d0, v0: w_v0,
                            pfn1: w_pfn1, c1: w_c1, d1: w_d1, v1: w_v1};
    end
  end

  tlb_entry_t r_entry;
  assign r_entry = entries[r_index];
  assign r_vpn2  = r_entry.vpn2;
  assign r_asid  = r_entry.asid;
  assign r_g     = r_entry.g;
  assign r_pfn0  = r_entry.pfn0;
  assign r_c0    = r_entry.c0;
  assign r_d0    = r_entry.d0;
  assign r_v0    = r_entry.v0;
  assign r_pfn1  = r_entry.pfn1;
  assign r_c1    = r_entry.c1;
  assign r_d1    = r_entry.d1;
  assign r_v1    = r_entry.v1;

  // One comparator per slot of the current group; the group counter steers the mux.
  for (genvar i = 0; i < GRP; i++) begin : g_match
    logic [IDX_W-1:0] sel;
    assign sel = IDX_W'(int'(grp_q) * GRP + i);

    tlb_entry_match u_match (
      .entry_vpn2 (entries[sel].vpn2),
      .entry_asid (entries[sel].asid),
      .entry_g    (entries[sel].g),
      .key_vpn2   (key_vpn2_q),
      .key_asid   (key_asid_q),
      .hit        (hits[i])
    );
  end

  always_comb begin
    first_hit = '0;
    for (int i = GRP - 1; i >= 0; i--) begin
      if (hits[i]) first_hit = SUB_W'(i);
    end
  end

  assign scan_index = IDX_W'(int'(grp_q) * GRP + int'(first_hit));

  always_comb begin
    state_d  = state_q;
    grp_d    = grp_q;
    found_d  = found_q;
    index_d  = index_q;
    load_key = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        grp_d   = '0;
        found_d = 1'b0;
        index_d = '0;
        if (TLBP) begin
          load_key = 1'b1;
          state_d  = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (!TLBP) begin
          state_d = ST_IDLE;
        end else if (we) begin
          // A TLBWI under an in-flight probe invalidates partial results; rescan with the same key.
          grp_d   = '0;
          found_d = 1'b0;
          index_d = '0;
        end else begin
          if (!found_q && (|hits)) begin
            found_d = 1'b1;
            index_d = scan_index;
          end
          if (grp_q == LAST_GRP) state_d = ST_DONE;
          else                   grp_d   = grp_q + GRP_W'(1);
        end
      end
      ST_DONE: begin
        if (!TLBP) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grp_q   <= '0;
      found_q <= 1'b0;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      found_q <= found_d;
      index_q <= index_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load_key) begin
      key_vpn2_q <= EntryHi[EHI_VPN2_MSB:EHI_VPN2_LSB];
      key_asid_q <= EntryHi[EHI_ASID_MSB:0];
    end
  end

  assign TLBP_result = (state_q == ST_DONE) ? pack_result(1'b1, found_q, index_q) : '0;

endmodule

// File: tb/tb_tlb_probe_array.sv
// tb/tb_tlb_probe_array.sv - self-checking bench for tlb_probe_array with a table-scan reference model
module tb_tlb_probe_array;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [3:0]  w_index;
  logic [18:0] w_vpn2;
  logic [7:0]  w_asid;
  logic        w_g;
  logic [19:0] w_pfn0, w_pfn1;
  logic [2:0]  w_c0, w_c1;
  logic        w_d0, w_v0, w_d1, w_v1;
  logic [3:0]  r_index;
  logic [18:0] r_vpn2;
  logic [7:0]  r_asid;
  logic        r_g;
  logic [19:0] r_pfn0, r_pfn1;
  logic [2:0]  r_c0, r_c1;
  logic        r_d0, r_v0, r_d1, r_v1;
  logic        TLBP;
  logic [31:0] EntryHi;
  logic [5:0]  TLBP_result;

  int checks   = 0;
  int failures = 0;

  logic [18:0] m_vpn2 [16];
  logic [7:0]  m_asid [16];
  logic        m_g    [16];
  logic [19:0] m_pfn0 [16];
  logic [19:0] m_pfn1 [16];
  logic [2:0]  m_c0   [16];
  logic [2:0]  m_c1   [16];
  logic        m_d0   [16];
  logic        m_v0   [16];
  logic        m_d1   [16];
  logic        m_v1   [16];

  tlb_probe_array dut (
    .clk(clk), .reset(reset),
    .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
    .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
    .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
    .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
    .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
    .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1),
    .TLBP(TLBP), .EntryHi(EntryHi), .TLBP_result(TLBP_result)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference probe: linear scan of the whole table, lowest matching index wins.
  function automatic logic [5:0] model_probe(input logic [31:0] hi);
    logic [18:0] kv;
    logic [7:0]  ka;
    kv = hi[31:13];
    ka = hi[7:0];
    for (int i = 0; i < 16; i++) begin
      if (m_vpn2[i] == kv && (m_g[i] || m_asid[i] == ka)) return {2'b11, 4'(i)};
    end
    return 6'b10_0000;
  endfunction

  function automatic logic [77:0] model_entry(input int i);
    return {m_vpn2[i], m_asid[i], m_g[i], m_pfn0[i], m_c0[i], m_d0[i], m_v0[i],
            m_pfn1[i], m_c1[i], m_d1[i], m_v1[i]};
  endfunction

  function automatic logic [77:0] dut_entry();
    return {r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_g[i]  = 1'b0;
      m_v0[i] = 1'b0;
      m_v1[i] = 1'b0;
    end
  endtask

  task automatic drive_write(input logic [3:0] idx, input logic [18:0] vpn2,
                             input logic [7:0] asid, input logic g);
    w_index = idx;  w_vpn2 = vpn2;  w_asid = asid;  w_g = g;
    w_pfn0 = 20'($urandom); w_c0 = 3'($urandom); w_d0 = 1'($urandom); w_v0 = 1'($urandom);
    w_pfn1 = 20'($urandom); w_c1 = 3'($urandom); w_d1 = 1'($urandom); w_v1 = 1'($urandom);
    we = 1'b1;
    m_vpn2[idx] = vpn2;   m_asid[idx] = asid;   m_g[idx] = g;
    m_pfn0[idx] = w_pfn0; m_c0[idx] = w_c0; m_d0[idx] = w_d0; m_v0[idx] = w_v0;
    m_pfn1[idx] = w_pfn1; m_c1[idx] = w_c1; m_d1[idx] = w_d1; m_v1[idx] = w_v1;
  endtask

  task automatic do_write(input logic [3:0] idx, input logic [18:0] vpn2,
                          input logic [7:0] asid, input logic g);
    drive_write(idx, vpn2, asid, g);
    tick();
    we = 1'b0;
  endtask

  // Raises TLBP in an IDLE cycle T, samples the result in T+5, then drops TLBP.
  task automatic run_probe(input logic [31:0] hi, output logic [5:0] res, output int early);
    TLBP = 1'b1;
    EntryHi = hi;
    early = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (TLBP_result[5] !== 1'b0) early++;
    end
    tick();
    res = TLBP_result;
    TLBP = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (TLBP_result !== 6'b0) begin
      failures++;
      $display("FAIL reset_result: got %b expected %b", TLBP_result, 6'b0);
    end
    model_reset();
    for (int i = 0; i < 16; i++) begin
      r_index = 4'(i);
      #1;
      checks++;
      if ({r_g, r_v0, r_v1} !== 3'b000) begin
        failures++;
        $display("FAIL reset_entry_gv[%0d]: got %b expected 000", i, {r_g, r_v0, r_v1});
      end
    end
    reset = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) do_write(4'(i), 19'h70000 + 19'(i), 8'(i), 1'b0);
  endtask

  task automatic test_read_write();
    logic [19:0] old_pfn0, new_pfn0;
    r_index  = 4'd7;
    old_pfn0 = m_pfn0[7];
    drive_write(4'd7, m_vpn2[7], m_asid[7], m_g[7]);
    new_pfn0 = ~old_pfn0;
    w_pfn0   = new_pfn0;
    m_pfn0[7] = new_pfn0;
    #1;
    checks++;
    if (r_pfn0 !== old_pfn0) begin
      failures++;
      $display("FAIL read_same_cycle: got %h expected %h", r_pfn0, old_pfn0);
    end
    tick();
    we = 1'b0;
    #1;
    checks++;
    if (r_pfn0 !== new_pfn0) begin
      failures++;
      $display("FAIL read_next_cycle: got %h expected %h", r_pfn0, new_pfn0);
    end
    for (int n = 0; n < 6; n++) begin
      r_index = 4'($urandom_range(0, 15));
      #1;
      checks++;
      if (dut_entry() !== model_entry(int'(r_index))) begin
        failures++;
        $display("FAIL read_entry[%0d]: got %h expected %h", r_index, dut_entry(), model_entry(int'(r_index)));
      end
    end
  endtask

  task automatic test_probe_basic();
    logic [5:0] res;
    int early;
    do_write(4'd5, 19'h12345, 8'h01, 1'b0);
    run_probe(32'h2468A001, res, early);
    checks++;
    if (res !== 6'b11_0101) begin
      failures++;
      $display("FAIL probe_basic: got %b expected %b", res, 6'b11_0101);
    end
    checks++;
    if (early !== 0) begin
      failures++;
      $display("FAIL probe_basic_latency: valid early %0d times, expected 0", early);
    end
    checks++;
    if (TLBP_result !== 6'b0) begin
      failures++;
      $display("FAIL probe_basic_idle: got %b expected %b", TLBP_result, 6'b0);
    end
  endtask

  task automatic test_probe_asid_global();
    logic [5:0] res;
    int early;
    run_probe(32'h2468A002, res, early);
    checks++;
    if (res !== 6'b10_0000) begin
      failures++;
      $display("FAIL probe_asid_miss: got %b expected %b", res, 6'b10_0000);
    end
    do_write(4'd5, 19'h12345, 8'h01, 1'b1);
    run_probe(32'h2468A002, res, early);
    checks++;
    if (res !== 6'b11_0101) begin
      failures++;
      $display("FAIL probe_global_hit: got %b expected %b", res, 6'b11_0101);
    end
    run_probe(32'h2468A0FF, res, early);
    checks++;
    if (res !== 6'b11_0101) begin
      failures++;
      $display("FAIL probe_global_any_asid: got %b expected %b", res, 6'b11_0101);
    end
  endtask

  task automatic test_multi_match();
    logic [5:0] res;
    int early;
    do_write(4'd3,  19'h2AAAA, 8'h33, 1'b0);
    do_write(4'd12, 19'h2AAAA, 8'h33, 1'b0);
    do_write(4'd13, 19'h2AAAA, 8'h33, 1'b1);
    run_probe({19'h2AAAA, 5'd0, 8'h33}, res, early);
    checks++;
    if (res !== 6'b11_0011) begin
      failures++;
      $display("FAIL multi_match_lowest: got %b expected %b", res, 6'b11_0011);
    end
  endtask

  task automatic test_write_restart();
    logic [31:0] key;
    logic [5:0]  exp;
    int early;
    key = {m_vpn2[14], 5'd0, m_asid[14]};
    TLBP = 1'b1;
    EntryHi = key;
    tick();
    tick();
    drive_write(4'd14, 19'h5F0F0, 8'hEE, 1'b0);
    tick();
    we = 1'b0;
    early = 0;
    for (int k = 4; k <= 6; k++) begin
      tick();
      if (TLBP_result[5] !== 1'b0) early++;
    end
    checks++;
    if (early !== 0) begin
      failures++;
      $display("FAIL restart_latency: valid early %0d times, expected 0", early);
    end
    tick();
    exp = model_probe(key);
    checks++;
    if (TLBP_result !== exp || exp !== 6'b10_0000) begin
      failures++;
      $display("FAIL restart_result: got %b expected %b", TLBP_result, 6'b10_0000);
    end
    TLBP = 1'b0;
    tick();
  endtask

  task automatic test_hold_in_done();
    logic [5:0] held;
    do_write(4'd9, 19'h3C3C3, 8'h99, 1'b0);
    TLBP = 1'b1;
    EntryHi = {19'h3C3C3, 5'd0, 8'h99};
    for (int k = 0; k < 5; k++) tick();
    held = TLBP_result;
    checks++;
    if (held !== 6'b11_1001) begin
      failures++;
      $display("FAIL done_result: got %b expected %b", held, 6'b11_1001);
    end
    do_write(4'd9, 19'h01010, 8'h99, 1'b0);
    tick();
    checks++;
    if (TLBP_result !== 6'b11_1001) begin
      failures++;
      $display("FAIL done_hold_after_write: got %b expected %b", TLBP_result, 6'b11_1001);
    end
    TLBP = 1'b0;
    tick();
    checks++;
    if (TLBP_result !== 6'b0) begin
      failures++;
      $display("FAIL done_release: got %b expected %b", TLBP_result, 6'b0);
    end
  endtask

  task automatic test_abort_and_reset();
    int seen;
    logic [5:0] res;
    int early;
    TLBP = 1'b1;
    EntryHi = {m_vpn2[5], 5'd0, 8'h01};
    tick();
    tick();
    tick();
    TLBP = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (TLBP_result !== 6'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL abort_no_result: nonzero result %0d cycles, expected 0", seen);
    end
    run_probe({m_vpn2[5], 5'd0, 8'h01}, res, early);
    checks++;
    if (res !== model_probe({m_vpn2[5], 5'd0, 8'h01}) || early !== 0) begin
      failures++;
      $display("FAIL abort_then_probe: got %b early %0d expected %b early 0", res, early,
               model_probe({m_vpn2[5], 5'd0, 8'h01}));
    end
    TLBP = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    reset = 1'b1;
    tick();
    checks++;
    if (TLBP_result !== 6'b0) begin
      failures++;
      $display("FAIL reset_in_done: got %b expected %b", TLBP_result, 6'b0);
    end
    reset = 1'b0;
    TLBP = 1'b0;
    model_reset();
    tick();
    TLBP = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (TLBP_result !== 6'b0) begin
      failures++;
      $display("FAIL reset_in_scan: got %b expected %b", TLBP_result, 6'b0);
    end
    reset = 1'b0;
    TLBP = 1'b0;
    tick();
    checks++;
    if (TLBP_result !== 6'b0) begin
      failures++;
      $display("FAIL reset_in_scan_after: got %b expected %b", TLBP_result, 6'b0);
    end
  endtask

  task automatic test_random();
    logic [5:0]  res, exp;
    logic [31:0] hi;
    int early;
    for (int n = 0; n < 30; n++) begin
      for (int w = 0; w < int'($urandom_range(1, 3)); w++) begin
        do_write(4'($urandom_range(0, 15)), 19'h40000 + 19'($urandom_range(0, 3)),
                 8'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0));
      end
      hi = {19'h40000 + 19'($urandom_range(0, 3)), 5'($urandom), 8'($urandom_range(0, 3))};
      exp = model_probe(hi);
      run_probe(hi, res, early);
      checks++;
      if (res !== exp || early !== 0) begin
        failures++;
        $display("FAIL random_probe[%0d]: key %h got %b early %0d expected %b", n, hi, res, early, exp);
      end
      r_index = 4'($urandom_range(0, 15));
      #1;
      checks++;
      if (dut_entry() !== model_entry(int'(r_index))) begin
        failures++;
        $display("FAIL random_read[%0d]: got %h expected %h", r_index, dut_entry(), model_entry(int'(r_index)));
      end
    end
  endtask

  initial begin
    reset = 1'b1;  we = 1'b0;  w_index = '0;  w_vpn2 = '0;  w_asid = '0;  w_g = 1'b0;
    w_pfn0 = '0;  w_c0 = '0;  w_d0 = 1'b0;  w_v0 = 1'b0;
    w_pfn1 = '0;  w_c1 = '0;  w_d1 = 1'b0;  w_v1 = 1'b0;
    r_index = '0;  TLBP = 1'b0;  EntryHi = '0;
    test_reset();
    test_read_write();
    test_probe_basic();
    test_probe_asid_global();
    test_multi_match();
    test_write_restart();
    test_hold_in_done();
    test_abort_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tlb_probe_array.md
TLB_PROBE_ARRAY -- requirements
Module: tlb_probe_array

Interface
REQ-001 SHALL have parameter TLBNUM, default 16, number of TLB entries; index width log2(TLBNUM)=4.
REQ-002 SHALL have parameter GRP, default 4, entries compared per scan cycle.
REQ-003 SHALL have ports: clk  input  1  system clock, single clock domain, rising edge.
REQ-004 SHALL have ports: reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports: we  input  1  write strobe (TLBWI); w_index  input  4  target entry.
REQ-006 SHALL have ports: w_vpn2  input  19;  w_asid  input  8;  w_g  input  1.
REQ-007 SHALL have ports: w_pfn0  input  20;  w_c0  input  3;  w_d0, w_v0  input  1 each.
REQ-008 SHALL have ports: w_pfn1  input  20;  w_c1  input  3;  w_d1, w_v1  input  1 each.
REQ-009 SHALL have ports: r_index  input  4  read entry select (TLBR).
REQ-010 SHALL have ports: r_vpn2 output 19; r_asid output 8; r_g output 1; r_pfn0/r_pfn1 output 20; r_c0/r_c1 output 3; r_d0, r_v0, r_d1, r_v1 output 1 each.
REQ-011 SHALL have ports: TLBP  input  1  probe request, level, held high while the TLBP instruction sits in WB.
REQ-012 SHALL have ports: EntryHi  input  32  probe key; VPN2=[31:13], ASID=[7:0].
REQ-013 SHALL have ports: TLBP_result  output  6  {valid[5], found[4], index[3:0]}.

Function
REQ-014 Entry match SHALL be: entry.vpn2==key.vpn2 AND (entry.g OR entry.asid==key.asid).
REQ-015 Write SHALL update all fields of entry[w_index] at the clk edge where we=1; g stored as w_g.
REQ-016 Read port SHALL be combinational from entry[r_index]; same-cycle write returns old data, new data next cycle.
REQ-017 Probe FSM states SHALL be IDLE, SCAN, DONE; 2-bit group counter grp.
REQ-018 IDLE: TLBP=1 -> latch VPN2/ASID from EntryHi, clear found, grp=0, go SCAN.
REQ-019 SCAN: compare entries grp*4..grp*4+3 against latched key; first match (lowest index) sets found/index only if not already found; grp==3 -> DONE, else grp+1.
REQ-020 DONE: TLBP_result = {1, found, index}; stay while TLBP=1; TLBP=0 -> IDLE.
REQ-021 Latency SHALL be: TLBP rises in cycle T (FSM IDLE) -> valid=1 in cycle T+5.
REQ-022 TLBP_result[5] SHALL be 0 outside DONE; found/index SHALL be 0 when valid=0.
REQ-023 No match: DONE with found=0, index=0.
REQ-024 TLBP falling in SCAN SHALL return FSM to IDLE next cycle, no result.
REQ-025 we=1 while in SCAN SHALL restart the scan: grp=0, found cleared, key kept.
REQ-026 we=1 in DONE SHALL NOT change the held result.
REQ-027 Multiple matches SHALL report the lowest index.

Reset
REQ-028 On reset: FSM=IDLE, grp=0, found=0, index=0, TLBP_result=6'b0.
REQ-029 On reset: every entry's g, v0, v1 cleared; other entry fields undefined.
REQ-030 Reset mid-SCAN or in DONE SHALL abort to IDLE; TLBP_result=0 next cycle.

Structure
REQ-031 TLBNUM, GRP, state encodings, TLBP_result field offsets SHALL be in the shared header (mycpu.h), with TLBP_result width = 6.
REQ-032 One sub-module tlb_entry_match (one entry vs key -> hit) SHALL be instantiated GRP times on the muxed scan group.
REQ-033 Entry storage SHALL be flops (no RAM macro) so read and scan are combinational.

Verification
REQ-034 Write entry 5 {vpn2=0x12345, asid=0x01, g=0}; probe EntryHi=0x2468A001 -> T+5 result=6'b11_0101.
REQ-035 Same entry, probe ASID=0x02 -> found=0, result=6'b10_0000; rewrite with g=1, repeat -> 6'b11_0101.
REQ-036 Identical vpn2/asid in entries 3 and 12; probe -> index=3.
REQ-037 Probe for entry 14's key; we=1 to entry 14 at T+2 (new vpn2) -> scan restarts, result at T+7 reflects new contents (found=0).
REQ-038 TLBP dropped at T+3 -> IDLE at T+4, valid never asserted; reset asserted in DONE -> TLBP_result=0 next cycle.
REQ-039 we to r_index=7 with new pfn0 -> r_pfn0 old same cycle, new next cycle.
